gemm_tile_sequencer: RTL and testbench
======================================

# gemm_tile_sequencer

Runtime tile walker for the weight-stationary systolic array. It accepts matrix dimensions M×K (activations) and K×N (weights) at run time, in place of compile-time matrix sizes. It emits one descriptor per tile (offsets, lengths, accumulation flags) to the buffer loaders and array controller. It sits between the host/config interface and the input/weight buffer address generators.

## Interface

Parameters:
- SYS_ROWS, 4: array rows; K-chunk per tile.
- SYS_COLS, 2: array columns; N-chunk per tile.
- M_TILE, 16: activation rows per tile; equals input buffer depth.
- DIM_W, 8: width of every dimension, offset and length field. Maximum dimension is 2^DIM_W−1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  sequencer idle and able to accept a config.
- cfg_m, cfg_k, cfg_n  in  DIM_W each  matrix dimensions.
- tile_valid  out  1  descriptor valid.
- tile_ready  in  1  consumer accepts the descriptor.
- tile_m_off, tile_k_off, tile_n_off  out  DIM_W each  element offsets of the tile.
- tile_m_len, tile_k_len, tile_n_len  out  DIM_W each  tile extents; each is ≥1 and ≤ M_TILE / SYS_ROWS / SYS_COLS respectively.
- tile_first_k  out  1  first K-chunk; consumer clears the accumulator.
- tile_last_k  out  1  last K-chunk; consumer drains the outputs.
- tile_last  out  1  final tile of the job.
- busy  out  1  a job is in progress.
- done  out  1  one-cycle pulse at job end.
- err  out  1  one-cycle pulse when a config is rejected.

## Operation

- FSM states are IDLE, RUN and FIN.
  - **IDLE:** cfg_ready=1. A config handshake (cfg_valid && cfg_ready) latches cfg_m, cfg_k and cfg_n.
    - If any dimension is 0: err pulses in the next cycle and the FSM stays in IDLE. No tiles are emitted.
    - Otherwise the offsets clear to 0 and the FSM goes to RUN.
  - **RUN:** tile_valid=1 and busy=1. On a tile handshake (tile_valid && tile_ready) the FSM advances to the next tile. When the tile flagged tile_last is accepted, the FSM goes to FIN.
  - **FIN:** lasts one cycle, with done=1 and busy=0. Then the FSM returns to IDLE.
- Loop order is n outer, m middle, k inner, so all K-chunks of one output block are contiguous.
  - k_off steps by SYS_ROWS. When k_off+SYS_ROWS ≥ K, k_off wraps to 0 and m_off steps by M_TILE.
  - When m_off wraps, n_off steps by SYS_COLS.
- Length of each tile dimension = min(tile size, dim − off).
- Flags:
  - tile_first_k = (k_off==0).
  - tile_last_k = (k_off+SYS_ROWS ≥ K).
  - tile_last = last_k && last_m && last_n.
- Arithmetic: the sums off+step and the comparisons against the dimension are computed at DIM_W+1 bits, so a dimension near 2^DIM_W−1 never wraps falsely.
- Tile count = ceil(N/SYS_COLS)·ceil(M/M_TILE)·ceil(K/SYS_ROWS).
- cfg_valid is ignored while the FSM is in RUN or FIN. The latched dimensions are unaffected.

## Timing

- All outputs are registered.
- Reset values: cfg_ready=0, tile_valid=0, busy=0, done=0, err=0, every offset/length/flag field =0, FSM in IDLE.
- cfg_ready rises in the first cycle after rst deasserts.
- Config accepted at edge t: tile_valid=1 with the first descriptor from cycle t+1; cfg_ready=0 from t+1.
- Throughput is one tile per cycle while tile_ready=1.
- When tile_valid=1 and tile_ready=0, every descriptor field stays stable. tile_valid never drops before a handshake.
- Last handshake at edge t: tile_valid=0, done=1 and cfg_ready=0 during cycle t+1. cfg_ready=1 from t+2.
- A back-to-back config can be accepted at edge t+2.
- Rejected config at edge t: err=1 during cycle t+1 only. cfg_ready stays 1.
- rst asserted mid-job: all outputs return to their reset values immediately (asynchronously). The job is abandoned. No done or err pulse is produced.

## Test plan

- Basic tiling, M=5, K=6, N=3, tile_ready held 1 (defaults SYS_ROWS=4, SYS_COLS=2, M_TILE=16):
  - 2 tiles, in order: (m0,k0,n0; lens 5,4,2; first_k), then (m0,k4,n0; lens 5,2,2; last_k).
  - Then 2 tiles at n_off=2 with n_len=1; the second has tile_last=1.
  - done pulses one cycle after the last handshake.
- Multiple M tiles, M=20, K=4, N=2:
  - 2 tiles: (m0, m_len 16) and (m16, m_len 4).
  - Each tile has first_k=1 and last_k=1; the second has tile_last=1.
- Backpressure: same job as the basic-tiling case with tile_ready toggled 1,0,0,1 repeatedly.
  - Descriptors stay frozen while ready=0.
  - The sequence is identical to the basic-tiling case; no tiles are skipped or duplicated.
- Zero dimension: cfg_k=0 → err pulses once, no tile_valid, cfg_ready stays 1.
  - A following valid config runs normally.
- Boundary values, DIM_W=8, M=K=N=255:
  - Last tile has offsets m240, k252, n254 and lengths 15, 3, 1.
  - Total tile count = 128·16·64 = 131072.
- Reset mid-job: assert rst after the 3rd tile handshake.
  - Outputs drop to their reset values immediately.
  - A new config with M=1, K=1, N=1 after release yields exactly one tile, with first_k, last_k and tile_last all 1.

Source files
------------

// File: rtl/gemm_tile_sequencer.sv
// Runtime tile walker for the weight-stationary systolic array.
// Walks n (outer), m (middle), k (inner) and emits one registered descriptor per tile.
module gemm_tile_sequencer #(
  parameter int unsigned SYS_ROWS = 4,
  parameter int unsigned SYS_COLS = 2,
  parameter int unsigned M_TILE   = 16,
  parameter int unsigned DIM_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIM_W-1:0] cfg_m,
  input  logic [DIM_W-1:0] cfg_k,
  input  logic [DIM_W-1:0] cfg_n,
  output logic             tile_valid,
  input  logic             tile_ready,
  output logic [DIM_W-1:0] tile_m_off,
  output logic [DIM_W-1:0] tile_k_off,
  output logic [DIM_W-1:0] tile_n_off,
  output logic [DIM_W-1:0] tile_m_len,
  output logic [DIM_W-1:0] tile_k_len,
  output logic [DIM_W-1:0] tile_n_len,
  output logic             tile_first_k,
  output logic             tile_last_k,
  output logic             tile_last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // One extra bit so off+step never wraps against a near-maximum dimension.
  localparam int unsigned XW = DIM_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t           state, state_nxt;
  logic [DIM_W-1:0] dim_m, dim_k, dim_n;
  logic             last_m, last_n;

  logic             cfg_hs, tile_hs, reject, load;
  logic [DIM_W-1:0] d_m, d_k, d_n;
  logic [DIM_W-1:0] o_m, o_k, o_n;
  logic [XW-1:0]    step_m, step_k, step_n;

  logic [XW-1:0]    sum_m, sum_k, sum_n;
  logic [XW-1:0]    rem_m, rem_k, rem_n;
  logic [DIM_W-1:0] nx_m_len, nx_k_len, nx_n_len;
  logic             nx_last_m, nx_last_k, nx_last_n;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state and selection of the offsets/dimensions for the next descriptor
  always_comb begin
    state_nxt = state;
    cfg_hs    = cfg_valid && cfg_ready;
    tile_hs   = tile_valid && tile_ready;
    reject    = 1'b0;
    load      = 1'b0;
    d_m       = dim_m;
    d_k       = dim_k;
    d_n       = dim_n;
    o_m       = tile_m_off;
    o_k       = tile_k_off;
    o_n       = tile_n_off;
    step_m    = XW'(tile_m_off) + XW'(M_TILE);
    step_k    = XW'(tile_k_off) + XW'(SYS_ROWS);
    step_n    = XW'(tile_n_off) + XW'(SYS_COLS);
    case (state)
      S_IDLE: begin
        if (cfg_hs) begin
          d_m = cfg_m;
          d_k = cfg_k;
          d_n = cfg_n;
          if (cfg_m == '0 || cfg_k == '0 || cfg_n == '0) begin
            reject = 1'b1;
          end else begin
            state_nxt = S_RUN;
            load      = 1'b1;
            o_m       = '0;
            o_k       = '0;
            o_n       = '0;
          end
        end
      end
      S_RUN: begin
        if (tile_hs) begin
          if (tile_last) begin
            state_nxt = S_FIN;
          end else begin
            load = 1'b1;
            if (!tile_last_k) begin
              o_k = DIM_W'(step_k);
            end else begin
              o_k = '0;
              if (!last_m) begin
                o_m = DIM_W'(step_m);
              end else begin
                o_m = '0;
                o_n = DIM_W'(step_n);
              end
            end
          end
        end
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Lengths and flags of the next descriptor
  always_comb begin
    sum_m     = XW'(o_m) + XW'(M_TILE);
    sum_k     = XW'(o_k) + XW'(SYS_ROWS);
    sum_n     = XW'(o_n) + XW'(SYS_COLS);
    rem_m     = XW'(d_m) - XW'(o_m);
    rem_k     = XW'(d_k) - XW'(o_k);
    rem_n     = XW'(d_n) - XW'(o_n);
    nx_last_m = sum_m >= XW'(d_m);
    nx_last_k = sum_k >= XW'(d_k);
    nx_last_n = sum_n >= XW'(d_n);
    nx_m_len  = (rem_m > XW'(M_TILE))   ? DIM_W'(M_TILE)   : DIM_W'(rem_m);
    nx_k_len  = (rem_k > XW'(SYS_ROWS)) ? DIM_W'(SYS_ROWS) : DIM_W'(rem_k);
    nx_n_len  = (rem_n > XW'(SYS_COLS)) ? DIM_W'(SYS_COLS) : DIM_W'(rem_n);
  end

  // Registered outputs, latched dimensions and descriptor fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_ready    <= 1'b0;
      tile_valid   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      dim_m        <= '0;
      dim_k        <= '0;
      dim_n        <= '0;
      last_m       <= 1'b0;
      last_n       <= 1'b0;
      tile_m_off   <= '0;
      tile_k_off   <= '0;
      tile_n_off   <= '0;
      tile_m_len   <= '0;
      tile_k_len   <= '0;
      tile_n_len   <= '0;
      tile_first_k <= 1'b0;
      tile_last_k  <= 1'b0;
      tile_last    <= 1'b0;
    end else begin
      cfg_ready  <= (state_nxt == S_IDLE);
      tile_valid <= (state_nxt == S_RUN);
      busy       <= (state_nxt == S_RUN);
      done       <= (state_nxt == S_FIN);
      err        <= reject;
      if (cfg_hs) begin
        dim_m <= cfg_m;
        dim_k <= cfg_k;
        dim_n <= cfg_n;
      end
      if (load) begin
        tile_m_off   <= o_m;
        tile_k_off   <= o_k;
        tile_n_off   <= o_n;
        tile_m_len   <= nx_m_len;
        tile_k_len   <= nx_k_len;
        tile_n_len   <= nx_n_len;
        tile_first_k <= (o_k == '0);
        tile_last_k  <= nx_last_k;
        tile_last    <= nx_last_k && nx_last_m && nx_last_n;
        last_m       <= nx_last_m;
        last_n       <= nx_last_n;
      end
    end
  end

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Directed self-checking bench for gemm_tile_sequencer (default parameters).
module tb_gemm_tile_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid, cfg_ready;
  logic [7:0] cfg_m, cfg_k, cfg_n;
  logic       tile_valid, tile_ready;
  logic [7:0] tile_m_off, tile_k_off, tile_n_off;
  logic [7:0] tile_m_len, tile_k_len, tile_n_len;
  logic       tile_first_k, tile_last_k, tile_last;
  logic       busy, done, err;

  int checks = 0;
  int errors = 0;

  gemm_tile_sequencer dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_n(cfg_n),
    .tile_valid(tile_valid), .tile_ready(tile_ready),
    .tile_m_off(tile_m_off), .tile_k_off(tile_k_off), .tile_n_off(tile_n_off),
    .tile_m_len(tile_m_len), .tile_k_len(tile_k_len), .tile_n_len(tile_n_len),
    .tile_first_k(tile_first_k), .tile_last_k(tile_last_k), .tile_last(tile_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [63:0] act;
  assign act = {13'd0, tile_m_off, tile_k_off, tile_n_off,
                tile_m_len, tile_k_len, tile_n_len,
                tile_first_k, tile_last_k, tile_last};

  function automatic logic [63:0] dsc(input int mo, input int ko, input int no,
                                      input int ml, input int kl, input int nl,
                                      input bit f, input bit lk, input bit l);
    return {13'd0, 8'(mo), 8'(ko), 8'(no), 8'(ml), 8'(kl), 8'(nl), f, lk, l};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a config once the sequencer is ready; returns one cycle after the accept edge.
  task automatic cfg(input int m, input int k, input int n);
    for (int i = 0; i < 20 && !cfg_ready; i++) @(negedge clk);
    chk("cfg_ready_wait", 64'(cfg_ready), 64'd1);
    cfg_m = 8'(m); cfg_k = 8'(k); cfg_n = 8'(n);
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // Accept one tile with ready held high and compare it.
  task automatic take(input string tag, input logic [63:0] exp);
    tile_ready = 1'b1;
    for (int i = 0; i < 20 && !tile_valid; i++) @(negedge clk);
    chk({tag, "_valid"}, 64'(tile_valid), 64'd1);
    chk(tag, act, exp);
    @(negedge clk);
  endtask

  // Drain a whole job, counting tiles and keeping the final descriptor.
  task automatic drain(input int budget, output int cnt, output logic [63:0] lastd);
    cnt = 0;
    lastd = '0;
    tile_ready = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (tile_valid) begin
        cnt++;
        lastd = act;
        if (tile_last) begin
          @(negedge clk);
          break;
        end
      end
      @(negedge clk);
    end
  endtask

  logic [63:0] bexp [4];
  logic [63:0] prev, lastd;
  logic        hold;
  int          idx, cnt;

  initial begin
    bexp[0] = dsc(0, 0, 0, 5, 4, 2, 1, 0, 0);
    bexp[1] = dsc(0, 4, 0, 5, 2, 2, 0, 1, 0);
    bexp[2] = dsc(0, 0, 2, 5, 4, 1, 1, 0, 0);
    bexp[3] = dsc(0, 4, 2, 5, 2, 1, 0, 1, 1);

    rst = 1'b1; cfg_valid = 1'b0; cfg_m = '0; cfg_k = '0; cfg_n = '0; tile_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {act[50:0], cfg_ready, tile_valid, busy, done, err}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("cfg_ready_after_rst", 64'(cfg_ready), 64'd1);

    // Basic tiling
    cfg(5, 6, 3);
    chk("basic_busy", {busy, cfg_ready}, 64'b10);
    for (int t = 0; t < 4; t++) take($sformatf("basic_t%0d", t), bexp[t]);
    chk("basic_fin", {tile_valid, done, cfg_ready, busy}, 64'b0100);
    @(negedge clk);
    chk("basic_idle", {tile_valid, done, cfg_ready, busy}, 64'b0010);

    // Multiple M tiles
    cfg(20, 4, 2);
    take("multm_t0", dsc(0, 0, 0, 16, 4, 2, 1, 1, 0));
    take("multm_t1", dsc(16, 0, 0, 4, 4, 2, 1, 1, 1));
    chk("multm_done", 64'(done), 64'd1);

    // Backpressure with ready pattern 1,0,0,1
    cfg(5, 6, 3);
    idx = 0; hold = 1'b0; prev = '0;
    for (int c = 0; c < 60 && idx < 4; c++) begin
      tile_ready = ((c % 4) == 0) || ((c % 4) == 3);
      if (tile_valid) begin
        if (hold) chk("bp_hold", act, prev);
        if (tile_ready) begin
          chk($sformatf("bp_t%0d", idx), act, bexp[idx]);
          idx++;
          hold = 1'b0;
        end else begin
          prev = act;
          hold = 1'b1;
        end
      end
      @(negedge clk);
    end
    tile_ready = 1'b1;
    chk("bp_count", 64'(idx), 64'd4);
    chk("bp_done", {tile_valid, done}, 64'b01);

    // Zero dimension rejected, then a normal job
    cfg(3, 0, 2);
    chk("zero_err", {err, tile_valid, cfg_ready, busy}, 64'b1010);
    @(negedge clk);
    chk("zero_err_once", {err, tile_valid, cfg_ready}, 64'b001);
    cfg(20, 4, 2);
    take("after_zero_t0", dsc(0, 0, 0, 16, 4, 2, 1, 1, 0));
    take("after_zero_t1", dsc(16, 0, 0, 4, 4, 2, 1, 1, 1));

    // Near-maximum M and K: offsets 240/252 need the extra carry bit
    cfg(255, 255, 3);
    drain(5000, cnt, lastd);
    chk("max_mk_count", 64'(cnt), 64'd2048);
    chk("max_mk_last", lastd, dsc(240, 252, 2, 15, 3, 1, 0, 1, 1));
    chk("max_mk_done", 64'(done), 64'd1);

    // Near-maximum N
    cfg(1, 1, 255);
    drain(500, cnt, lastd);
    chk("max_n_count", 64'(cnt), 64'd128);
    chk("max_n_last", lastd, dsc(0, 0, 254, 1, 1, 1, 1, 1, 1));

    // Reset mid-job after the third handshake
    cfg(5, 6, 3);
    for (int t = 0; t < 3; t++) take($sformatf("rstjob_t%0d", t), bexp[t]);
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", {act[50:0], cfg_ready, tile_valid, busy, done, err}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_no_pulse", {done, err, tile_valid}, 64'b000);
    cfg(1, 1, 1);
    take("single_t0", dsc(0, 0, 0, 1, 1, 1, 1, 1, 1));
    chk("single_done", {tile_valid, done}, 64'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
